// File: rtl/clock_core_if.sv
// rtl/clock_core_if.sv - control and time-of-day bus between the clock core and its user
interface clock_core_if;
  logic       mode_12h;
  logic       set;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       alarm_en;
  logic       alarm_set;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_clear;
  logic       sec_tick;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hrs;
  logic       pm;
  logic       alarm_ring;
  logic       set_err;

  modport master (
    output mode_12h, set, set_hours, set_minutes, set_seconds,
           alarm_en, alarm_set, alarm_hours, alarm_minutes, alarm_clear,
    input  sec_tick, sec, min, hrs, pm, alarm_ring, set_err
  );

  modport slave (
    input  mode_12h, set, set_hours, set_minutes, set_seconds,
           alarm_en, alarm_set, alarm_hours, alarm_minutes, alarm_clear,
    output sec_tick, sec, min, hrs, pm, alarm_ring, set_err
  );
endinterface

// File: rtl/clock_core.sv
// rtl/clock_core.sv - prescaled HH:MM:SS time-of-day counter with load port, 12/24h view and one alarm
module clock_core #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int RING_SECS = 60
) (
  input  logic         clk_i,
  input  logic         reset_i,
  clock_core_if.slave  bus
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    RING_INIT = 8'(RING_SECS);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hrs_q, hrs_d;
  logic [4:0]    alarm_h_q, alarm_h_d;
  logic [5:0]    alarm_m_q, alarm_m_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          ring_q;
  logic [7:0]    ring_cnt_q;
  state_t        state_q;

  logic       set_range_ok, alarm_range_ok, set_ok, alarm_ok, terminal, alarm_hit;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hrs_inc, hrs_view;

  always_comb begin
    set_range_ok   = (bus.set_hours <= 5'd23) && (bus.set_minutes <= 6'd59) &&
                     (bus.set_seconds <= 6'd59);
    alarm_range_ok = (bus.alarm_hours <= 5'd23) && (bus.alarm_minutes <= 6'd59);
    set_ok         = bus.set && set_range_ok;
    alarm_ok       = bus.alarm_set && alarm_range_ok;
    err_d          = (bus.set && !set_range_ok) || (bus.alarm_set && !alarm_range_ok);
    terminal       = (presc_q == PRESC_MAX);
    // A valid load restarts the second, so a coincident terminal count is discarded.
    tick_d         = terminal && !set_ok;
    presc_d        = (set_ok || terminal) ? '0 : presc_q + 1'b1;

    sec_inc = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    min_inc = min_q;
    hrs_inc = hrs_q;
    if (sec_q == 6'd59) begin
      min_inc = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (min_q == 6'd59) begin
        hrs_inc = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
      end
    end

    sec_d = sec_q;
    min_d = min_q;
    hrs_d = hrs_q;
    if (set_ok) begin
      sec_d = bus.set_seconds;
      min_d = bus.set_minutes;
      hrs_d = bus.set_hours;
    end else if (tick_d) begin
      sec_d = sec_inc;
      min_d = min_inc;
      hrs_d = hrs_inc;
    end

    alarm_h_d = alarm_ok ? bus.alarm_hours   : alarm_h_q;
    alarm_m_d = alarm_ok ? bus.alarm_minutes : alarm_m_q;
    alarm_hit = tick_d && (hrs_inc == alarm_h_q) && (min_inc == alarm_m_q) && (sec_inc == 6'd0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q   <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hrs_q     <= '0;
      alarm_h_q <= '0;
      alarm_m_q <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hrs_q     <= hrs_d;
      alarm_h_q <= alarm_h_d;
      alarm_m_q <= alarm_m_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else if (!bus.alarm_en) begin
      state_q <= IDLE;
      ring_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= ARMED;
        end
        ARMED: begin
          // A clear arriving with the matching tick suppresses the ring entirely.
          if (alarm_hit && !bus.alarm_clear) begin
            state_q    <= RINGING;
            ring_q     <= 1'b1;
            ring_cnt_q <= RING_INIT;
          end
        end
        RINGING: begin
          if (bus.alarm_clear || (tick_d && ring_cnt_q <= 8'd1)) begin
            state_q <= ARMED;
            ring_q  <= 1'b0;
          end else if (tick_d) begin
            ring_cnt_q <= ring_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hrs_view = hrs_q;
    if (bus.mode_12h) begin
      if (hrs_q == 5'd0) begin
        hrs_view = 5'd12;
      end else if (hrs_q > 5'd12) begin
        hrs_view = hrs_q - 5'd12;
      end
    end
  end

  assign bus.sec_tick   = tick_q;
  assign bus.sec        = sec_q;
  assign bus.min        = min_q;
  assign bus.hrs        = hrs_view;
  assign bus.pm         = (hrs_q >= 5'd12);
  assign bus.alarm_ring = ring_q;
  assign bus.set_err    = err_q;

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - directed vector bench for clock_core with CLK_DIV=4, RING_SECS=3
module tb_clock_core;

  typedef struct {
    int h, m, s, mode, nticks;
    int exp_hrs, exp_min, exp_sec, exp_pm, exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[10];

  clock_core_if bus ();

  clock_core #(.CLK_DIV(4), .RING_SECS(3)) u_dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    bus.set_hours   = 5'(h);
    bus.set_minutes = 6'(m);
    bus.set_seconds = 6'(s);
    bus.set = 1'b1;
    clk1();
    bus.set = 1'b0;
  endtask

  task automatic do_alarm_set(input int h, input int m);
    bus.alarm_hours   = 5'(h);
    bus.alarm_minutes = 6'(m);
    bus.alarm_set = 1'b1;
    clk1();
    bus.alarm_set = 1'b0;
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      clk1();
      if (bus.sec_tick) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check("tick_timeout", 0, 1);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_hrs"}, int'(bus.hrs), h);
    check({name, "_min"}, int'(bus.min), m);
    check({name, "_sec"}, int'(bus.sec), s);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{23, 59, 59, 0, 1,  0,  0,  0, 0, 0};
    vecs[1] = '{13,  5,  0, 1, 0,  1,  5,  0, 1, 0};
    vecs[2] = '{24,  0,  0, 1, 0,  1,  5,  0, 1, 1};
    vecs[3] = '{10, 60,  0, 0, 0, 13,  5,  0, 1, 1};
    vecs[4] = '{11, 59, 59, 1, 1, 12,  0,  0, 1, 0};
    vecs[5] = '{12, 59, 59, 1, 1,  1,  0,  0, 1, 0};
    vecs[6] = '{ 0,  0, 59, 1, 2, 12,  1,  1, 0, 0};
    vecs[7] = '{ 9, 59, 58, 0, 3, 10,  0,  1, 0, 0};
    vecs[8] = '{ 5, 10, 61, 0, 0, 10,  0,  1, 0, 1};
    vecs[9] = '{22, 59, 59, 1, 1, 11,  0,  0, 1, 0};

    bus.mode_12h = 1'b0; bus.set = 1'b0; bus.set_hours = '0; bus.set_minutes = '0;
    bus.set_seconds = '0; bus.alarm_en = 1'b0; bus.alarm_set = 1'b0;
    bus.alarm_hours = '0; bus.alarm_minutes = '0; bus.alarm_clear = 1'b0;

    // Reset state and free-running prescaler
    clk1(); clk1();
    reset = 1'b0;
    check("rst_tick", int'(bus.sec_tick), 0);
    check_time("rst", 0, 0, 0);
    check("rst_pm", int'(bus.pm), 0);
    check("rst_ring", int'(bus.alarm_ring), 0);
    check("rst_err", int'(bus.set_err), 0);
    bus.mode_12h = 1'b1; #1;
    check("rst_hrs12", int'(bus.hrs), 12);
    bus.mode_12h = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      clk1();
      check($sformatf("run_tick_c%0d", c), int'(bus.sec_tick), (c == 4 || c == 8) ? 1 : 0);
    end
    check_time("run8", 0, 0, 2);

    // Table: load, optional ticks, compare displayed time
    for (int i = 0; i < 10; i++) begin
      bus.mode_12h = vecs[i].mode[0];
      do_set(vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("v%0d_err", i), int'(bus.set_err), vecs[i].exp_err);
      check($sformatf("v%0d_loadtick", i), int'(bus.sec_tick), 0);
      for (int t = 0; t < vecs[i].nticks; t++) wait_tick(cyc);
      check_time($sformatf("v%0d", i), vecs[i].exp_hrs, vecs[i].exp_min, vecs[i].exp_sec);
      check($sformatf("v%0d_pm", i), int'(bus.pm), vecs[i].exp_pm);
    end
    bus.mode_12h = 1'b0;

    // Load coincident with terminal count drops that tick
    do_set(1, 2, 3);
    clk1(); clk1(); clk1();
    do_set(4, 5, 6);
    check("coinc_tick", int'(bus.sec_tick), 0);
    check_time("coinc", 4, 5, 6);
    wait_tick(cyc);
    check("coinc_next_tick_cycles", cyc, 4);
    check("coinc_sec", int'(bus.sec), 7);

    // Alarm ring and automatic timeout
    bus.alarm_en = 1'b1;
    do_alarm_set(7, 30);
    do_alarm_set(24, 0);
    check("aset_bad_err", int'(bus.set_err), 1);
    do_set(7, 30, 0);
    clk1(); clk1();
    check("set_on_alarm_noring", int'(bus.alarm_ring), 0);
    do_set(7, 29, 59);
    wait_tick(cyc);
    check("ring_on", int'(bus.alarm_ring), 1);
    check_time("ring_on", 7, 30, 0);
    do_alarm_set(8, 15);
    check("ring_after_aset", int'(bus.alarm_ring), 1);
    wait_tick(cyc);
    check("ring_t1", int'(bus.alarm_ring), 1);
    wait_tick(cyc);
    check("ring_t2", int'(bus.alarm_ring), 1);
    wait_tick(cyc);
    check("ring_t3_off", int'(bus.alarm_ring), 0);

    // Still armed, new alarm time; then clear
    do_set(8, 14, 59);
    wait_tick(cyc);
    check("rearm_ring", int'(bus.alarm_ring), 1);
    bus.alarm_clear = 1'b1; clk1(); bus.alarm_clear = 1'b0;
    check("clear_ring", int'(bus.alarm_ring), 0);

    // alarm_en low drops ring
    do_set(8, 14, 59);
    wait_tick(cyc);
    check("en_ring", int'(bus.alarm_ring), 1);
    bus.alarm_en = 1'b0; clk1();
    check("en_off_ring", int'(bus.alarm_ring), 0);
    bus.alarm_en = 1'b1; clk1();

    // Reset while ringing
    do_set(8, 14, 59);
    wait_tick(cyc);
    check("prereset_ring", int'(bus.alarm_ring), 1);
    reset = 1'b1; clk1(); reset = 1'b0;
    check("reset_ring", int'(bus.alarm_ring), 0);
    check_time("reset", 0, 0, 0);

    // Clear on the entry cycle: ring never asserts
    clk1();
    do_alarm_set(7, 30);
    do_set(7, 29, 59);
    clk1(); clk1(); clk1();
    bus.alarm_clear = 1'b1; clk1(); bus.alarm_clear = 1'b0;
    check("entry_clr_tick", int'(bus.sec_tick), 1);
    check("entry_clr_min", int'(bus.min), 30);
    check("entry_clr_ring", int'(bus.alarm_ring), 0);
    clk1(); clk1();
    check("entry_clr_ring_later", int'(bus.alarm_ring), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
